cisr_row_decoder: RTL

- Consumer stage behind row_length_receiver and value_index_receiver.
- Buffers per-channel CISR row lengths and value/column-index beats, and tracks each channel's active row.
- Assigns global row IDs in CISR order.
- Emits one beat per handshake to the multiply/accumulate stage: value, column index, row ID, last-in-row flag and slot-valid per channel.

---
 rtl/cisr_row_decoder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/cisr_row_decoder.sv
// cisr_row_decoder: buffers CISR row lengths and value/index beats, assigns
// row IDs in CISR order. Define CISR_ROW_STATS_EN for zero_rows/pad_slots.
module cisr_row_decoder #(
    parameter int NUM_CHANNELS   = 4,
    parameter int LEN_FIFO_DEPTH = 8,
    parameter int VI_FIFO_DEPTH  = 4,
    parameter int ROW_ID_W       = 32
) (
    input  logic                             clk,
    input  logic                             rst_l,
    input  logic [NUM_CHANNELS*32-1:0]       row_lengths,
    input  logic                             len_rdy,
    input  logic                             len_done,
    input  logic [NUM_CHANNELS*32-1:0]       values,
    input  logic [NUM_CHANNELS*32-1:0]       column_indices,
    input  logic                             vi_rdy,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [NUM_CHANNELS*32-1:0]       out_values,
    output logic [NUM_CHANNELS*32-1:0]       out_col_indices,
    output logic [NUM_CHANNELS*ROW_ID_W-1:0] out_row_ids,
    output logic [NUM_CHANNELS-1:0]          out_slot_valid,
    output logic [NUM_CHANNELS-1:0]          out_row_last,
    output logic                             len_overflow,
    output logic                             vi_overflow,
`ifdef CISR_ROW_STATS_EN
    output logic [31:0]                      zero_rows,
    output logic [31:0]                      pad_slots,
`endif
    output logic                             done
);
    localparam int LA = $clog2(LEN_FIFO_DEPTH);
    localparam int VA = $clog2(VI_FIFO_DEPTH);
    localparam int CW = NUM_CHANNELS * 32;
    localparam int VW = 2 * CW;
    localparam logic [ROW_ID_W-1:0] ID_ONE = 1;
    localparam logic [LA:0]         LP_ONE = 1;
    localparam logic [VA:0]         VP_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISHED} state_t;
    state_t state;

    logic [31:0]             len_mem [NUM_CHANNELS][LEN_FIFO_DEPTH];
    logic [LA:0]             len_wp [NUM_CHANNELS];
    logic [LA:0]             len_rp [NUM_CHANNELS];
    logic [31:0]             len_head [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] len_empty;
    logic [NUM_CHANNELS-1:0] len_full;

    logic [VW-1:0]           vi_mem [VI_FIFO_DEPTH];
    logic [VA:0]             vi_wp;
    logic [VA:0]             vi_rp;
    logic [VW-1:0]           vi_head;
    logic                    vi_empty;
    logic                    vi_full;

    logic [31:0]             remain [NUM_CHANNELS];
    logic [ROW_ID_W-1:0]     cur_id [NUM_CHANNELS];
    logic [ROW_ID_W-1:0]     next_row_id;
    logic                    len_seen;

    logic                    live;
    logic                    len_push;
    logic                    vi_push;
    logic                    fire;
    logic                    stall;
    logic                    drained;
    logic [NUM_CHANNELS-1:0] busy;
    logic [NUM_CHANNELS-1:0] ch_ok;
    logic [NUM_CHANNELS-1:0] fetch;
    logic [ROW_ID_W-1:0]     fetch_id [NUM_CHANNELS];
    logic [ROW_ID_W-1:0]     fetch_cnt;

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            len_empty[c] = len_wp[c] == len_rp[c];
            len_full[c]  = (len_wp[c][LA] != len_rp[c][LA]) &&
                           (len_wp[c][LA-1:0] == len_rp[c][LA-1:0]);
            len_head[c]  = len_mem[c][len_rp[c][LA-1:0]];
            busy[c]      = remain[c] != 32'd0;
            // an idle channel is padding only once no more lengths can come
            ch_ok[c]     = busy[c] || (len_empty[c] && len_seen);
        end
    end

    assign vi_empty = vi_wp == vi_rp;
    assign vi_full  = (vi_wp[VA] != vi_rp[VA]) &&
                      (vi_wp[VA-1:0] == vi_rp[VA-1:0]);
    assign vi_head  = vi_mem[vi_rp[VA-1:0]];

    assign live      = state != FINISHED;
    assign len_push  = live && len_rdy && !(|len_full);
    assign vi_push   = live && vi_rdy && !vi_full;
    assign out_valid = !vi_empty && (&ch_ok);
    assign fire      = out_valid && out_ready;
    assign stall     = out_valid && !out_ready;
    assign drained   = (&len_empty) && vi_empty &&
                       !(|busy) && !out_valid;

    // lower channels take lower IDs within a cycle
    always_comb begin
        fetch_cnt = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            fetch[c]    = !busy[c] && !len_empty[c] && !stall;
            fetch_id[c] = next_row_id + fetch_cnt;
            if (fetch[c]) fetch_cnt = fetch_cnt + ID_ONE;
        end
    end

    always_comb begin
        out_values      = '0;
        out_col_indices = '0;
        out_row_ids     = '0;
        out_slot_valid  = '0;
        out_row_last    = '0;
        if (out_valid) begin
            out_values      = vi_head[VW-1:CW];
            out_col_indices = vi_head[CW-1:0];
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (busy[c]) begin
                    out_slot_valid[c] = 1'b1;
                    out_row_last[c]   = remain[c] == 32'd1;
                    out_row_ids[c*ROW_ID_W +: ROW_ID_W] = cur_id[c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (len_push) begin
            for (int c = 0; c < NUM_CHANNELS; c++)
                len_mem[c][len_wp[c][LA-1:0]] <= row_lengths[c*32 +: 32];
        end
        if (vi_push)
            vi_mem[vi_wp[VA-1:0]] <= {values, column_indices};
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state        <= IDLE;
            len_seen     <= 1'b0;
            len_overflow <= 1'b0;
            vi_overflow  <= 1'b0;
            done         <= 1'b0;
            next_row_id  <= '0;
            vi_wp        <= '0;
            vi_rp        <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                len_wp[c] <= '0;
                len_rp[c] <= '0;
                remain[c] <= '0;
                cur_id[c] <= '0;
            end
        end else begin
            if (live && len_rdy && (|len_full)) len_overflow <= 1'b1;
            if (live && vi_rdy && vi_full) vi_overflow <= 1'b1;
            if (vi_push) vi_wp <= vi_wp + VP_ONE;
            if (fire) vi_rp <= vi_rp + VP_ONE;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (len_push) len_wp[c] <= len_wp[c] + LP_ONE;
                if (fetch[c]) begin
                    len_rp[c] <= len_rp[c] + LP_ONE;
                    remain[c] <= len_head[c];
                    if (len_head[c] != 32'd0) cur_id[c] <= fetch_id[c];
                end else if (fire && busy[c]) begin
                    remain[c] <= remain[c] - 32'd1;
                end
            end
            next_row_id <= next_row_id + fetch_cnt;
            if (live && len_done) len_seen <= 1'b1;
            unique case (state)
                IDLE:     if (len_rdy || vi_rdy) state <= RUN;
                RUN:      if (len_seen) state <= DRAIN;
                DRAIN: begin
                    if (drained) begin
                        state <= FINISHED;
                        done  <= 1'b1;
                    end
                end
                FINISHED: done <= 1'b1;
                default:  state <= IDLE;
            endcase
        end
    end

`ifdef CISR_ROW_STATS_EN
    logic [31:0] zero_inc;
    logic [31:0] pad_inc;

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    always_comb begin
        zero_inc = '0;
        pad_inc  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (fetch[c] && len_head[c] == 32'd0) zero_inc = zero_inc + 32'd1;
            if (fire && !busy[c]) pad_inc = pad_inc + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            zero_rows <= '0;
            pad_slots <= '0;
        end else begin
            zero_rows <= sat_add(zero_rows, zero_inc);
            pad_slots <= sat_add(pad_slots, pad_inc);
        end
    end
`endif

endmodule
